// File: rtl/defines.sv
// Shared ALU data width and opcode encodings.
`ifndef ALU_DEFINES_SV
`define ALU_DEFINES_SV

`define DATA_BITS 8

`define SUM  8'h00
`define SUB  8'h01
`define MULT 8'h02
`define DIV  8'h03
`define INC  8'h04
`define DEC  8'h05
`define AND  8'h06
`define OR   8'h07
`define XOR  8'h08
`define COMP 8'h09

`endif

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one combinational ALU (IDLE -> EXEC -> RESP).
// Optional macro ALU_ARB_DIV_ZERO_EN: DIV with operand A == 0 returns all ones and raises respN_err.
`include "defines.sv"

module alu_arbiter (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [`DATA_BITS-1:0] req0_op,
    input  logic [`DATA_BITS-1:0] req0_a,
    input  logic [`DATA_BITS-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [`DATA_BITS-1:0] req1_op,
    input  logic [`DATA_BITS-1:0] req1_a,
    input  logic [`DATA_BITS-1:0] req1_b,
    output logic                  resp0_valid,
    input  logic                  resp0_ready,
    output logic [`DATA_BITS-1:0] resp0_result,
    output logic                  resp0_err,
    output logic                  resp1_valid,
    input  logic                  resp1_ready,
    output logic [`DATA_BITS-1:0] resp1_result,
    output logic                  resp1_err,
    output logic [`DATA_BITS-1:0] alu_data_A,
    output logic [`DATA_BITS-1:0] alu_data_B,
    output logic [`DATA_BITS-1:0] alu_op_code,
    input  logic [`DATA_BITS-1:0] alu_result
);
    localparam int W = `DATA_BITS;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state, state_nxt;
    logic           rr;
    logic           owner;
    logic           grant;
    logic           grant_vld;
    logic           xfer;
    logic           resp_hs;
    logic [W-1:0]   exec_res;
    logic           exec_err;

`ifdef ALU_ARB_DIV_ZERO_EN
    function automatic logic is_div_zero(input logic [W-1:0] op, input logic [W-1:0] a);
        return (op == `DIV) && (a == '0);
    endfunction
`endif

    // Round-robin pointer only breaks ties; a lone requester always wins.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant     = (req0_valid && req1_valid) ? rr : req1_valid;
    end

    always_comb begin
`ifdef ALU_ARB_DIV_ZERO_EN
        exec_err = is_div_zero(alu_op_code, alu_data_A);
        exec_res = exec_err ? {W{1'b1}} : alu_result;
`else
        exec_err = 1'b0;
        exec_res = alu_result;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        xfer        = 1'b0;
        resp_hs     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld && !rst) begin
                    req0_ready = ~grant;
                    req1_ready = grant;
                    xfer       = 1'b1;
                    state_nxt  = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                resp0_valid = ~owner;
                resp1_valid = owner;
                resp_hs     = owner ? resp1_ready : resp0_ready;
                if (resp_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU operands stay put from the accept edge until the next transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr           <= 1'b0;
            owner        <= 1'b0;
            alu_op_code  <= '0;
            alu_data_A   <= '0;
            alu_data_B   <= '0;
            resp0_result <= '0;
            resp1_result <= '0;
        end else begin
            if (xfer) begin
                owner       <= grant;
                alu_op_code <= grant ? req1_op : req0_op;
                alu_data_A  <= grant ? req1_a  : req0_a;
                alu_data_B  <= grant ? req1_b  : req0_b;
            end
            if (state == EXEC) begin
                if (owner) begin
                    resp1_result <= exec_res;
                end else begin
                    resp0_result <= exec_res;
                end
            end
            if (resp_hs) begin
                rr <= ~owner;
            end
        end
    end

`ifdef ALU_ARB_DIV_ZERO_EN
    logic err0_q, err1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else if (state == EXEC) begin
            if (owner) begin
                err1_q <= exec_err;
            end else begin
                err0_q <= exec_err;
            end
        end
    end

    assign resp0_err = err0_q;
    assign resp1_err = err1_q;
`else
    assign resp0_err = 1'b0;
    assign resp1_err = 1'b0;
`endif

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters: none; all data/opcode widths SHALL be `DATA_BITS` from defines.sv; opcodes SHALL use the defines.sv encodings (`SUM`..`COMP`).
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 reqN_valid  in  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_ready  out  1  arbiter accepts requester N's operation this cycle.
REQ-007 reqN_op  in  DATA_BITS  opcode.
REQ-008 reqN_a, reqN_b  in  DATA_BITS  operands A, B.
REQ-009 respN_valid  out  1  result for requester N available.
REQ-010 respN_ready  in  1  requester N consumes result.
REQ-011 respN_result  out  DATA_BITS  registered result.
REQ-012 respN_err  out  1  error flag qualifying respN_result.
REQ-013 alu_data_A, alu_data_B, alu_op_code  out  DATA_BITS  registered ALU operands/opcode.
REQ-014 alu_result  in  DATA_BITS  combinational ALU output.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, RESP.
REQ-016 IDLE: grant SHALL go to the single valid requester; if both valid, to the requester selected by round-robin pointer rr (rr=0 -> requester 0).
REQ-017 reqN_ready SHALL be high only in IDLE and only for the granted N; at most one reqN_ready high per cycle; transfer occurs when reqN_valid && reqN_ready.
REQ-018 On transfer: op/a/b SHALL be captured into alu_op_code/alu_data_A/alu_data_B, owner register set to N, state -> EXEC.
REQ-019 EXEC (exactly one cycle): alu_result SHALL be captured into respN_result of the owner, state -> RESP.
REQ-020 RESP: respN_valid SHALL be high for the owner only and held, with result/err stable, until respN_ready; on handshake state -> IDLE, rr <= owner ^ 1.
REQ-021 Latency: accept cycle T -> respN_valid first high at T+2; minimum issue interval 3 cycles with respN_ready tied high.
REQ-022 Non-owner respN_valid SHALL stay 0; non-owner reqN_valid changes during EXEC/RESP SHALL have no effect.
REQ-023 reqN_valid dropped in IDLE before transfer SHALL cancel that request with no state change.
REQ-024 rr SHALL update only on a completed response handshake; a single active requester SHALL be served back-to-back regardless of rr.
REQ-025 Unknown opcodes SHALL be forwarded unchanged; result is whatever alu_result returns (zero for the defined ALU).
REQ-026 ALU operands SHALL be held stable from EXEC through RESP.

Reset
REQ-027 rst SHALL force: state IDLE, rr=0, owner=0, all reqN_ready/respN_valid/respN_err=0, respN_result=0, alu_* =0.
REQ-028 rst asserted in EXEC or RESP SHALL abort the operation; no response is ever delivered for it.

Configuration
REQ-029 Macro ALU_ARB_DIV_ZERO_EN: when defined, an accepted `DIV` with operand A==0 SHALL skip alu_result and return respN_result = all ones, respN_err=1, same latency.
REQ-030 Without ALU_ARB_DIV_ZERO_EN: respN_err SHALL be constant 0 and divide-by-zero results SHALL be passed through from alu_result.

Verification
REQ-031 Reset then idle 5 cycles -> all outputs 0, no reqN_ready.
REQ-032 req0 `SUM` a=3 b=5 at cycle T, resp0_ready=1 -> resp0_valid at T+2, result 8, resp1_valid stays 0.
REQ-033 Both valid continuously, req0 `SUB` a=2 b=9, req1 `MULT` a=4 b=6 -> grants 0,1,0,1..., results 7 and 24 alternate.
REQ-034 req1 `INC` a=0xFF.., resp1_ready low 4 cycles -> resp1_valid held, result 0 stable, no new grant until handshake.
REQ-035 req0 `DIV` a=0 b=10 -> with ALU_ARB_DIV_ZERO_EN: result all ones, err=1; without: err=0, result = ALU value.
REQ-036 rst pulsed during EXEC of req0 `XOR` -> no resp0_valid afterwards; next request served normally from rr=0.
